// File: rtl/twos_deserializer.sv
// twos_deserializer: LSB-first serial two's-complement receiver that
// presents each completed word as sign + magnitude behind a valid/ready
// handshake.
// Optional feature macro: TWOS_OVR_EN
//   defined   -> a word completing while the held word is stalled is dropped
//                and the sticky ovr flag is raised.
//   undefined -> no ovr port; a stalled held word is overwritten.
//
// state | meaning
// IDLE  | waiting for a sof-qualified bit 0
// RECV  | collecting bits 1..WIDTH-1 of the current word
module twos_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             i,
    input  logic             v,
    input  logic             sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag,
    output logic             sign
`ifdef TWOS_OVR_EN
    ,
    output logic             ovr
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             seen_one, seen_one_nxt;
    logic [WIDTH-1:0] raw, raw_nxt;
    logic [WIDTH-1:0] neg, neg_nxt;
    logic             neg_bit;
    logic             done;
    logic             load;
    logic             valid_nxt;

    // Next-state, bit capture and completion decode.
    // Bits are written at their own position so the finished word is
    // already aligned; the negated copy inverts every bit above the first 1,
    // which is the bit-serial form of two's-complement negation.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        seen_one_nxt = seen_one;
        raw_nxt      = raw;
        neg_nxt      = neg;
        done         = 1'b0;
        neg_bit      = seen_one ? ~i : i;

        if (v && sof) begin
            raw_nxt      = {{(WIDTH-1){1'b0}}, i};
            neg_nxt      = {{(WIDTH-1){1'b0}}, i};
            seen_one_nxt = i;
            cnt_nxt      = CW'(1);
            state_nxt    = RECV;
        end else if (v && (state == RECV)) begin
            raw_nxt[cnt] = i;
            neg_nxt[cnt] = neg_bit;
            seen_one_nxt = seen_one | i;
            if (cnt == LAST) begin
                done      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

`ifdef TWOS_OVR_EN
        // A stalled held word wins; the newcomer is discarded.
        load = done && !(out_valid && !out_ready);
`else
        load = done;
`endif

        if (done) begin
            valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end else begin
            valid_nxt = out_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture registers and the output word/handshake.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            cnt       <= '0;
            seen_one  <= 1'b0;
            raw       <= '0;
            neg       <= '0;
            out_valid <= 1'b0;
            mag       <= '0;
            sign      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            seen_one  <= seen_one_nxt;
            raw       <= raw_nxt;
            neg       <= neg_nxt;
            out_valid <= valid_nxt;
            if (load) begin
                sign <= i;
                mag  <= i ? neg_nxt : raw_nxt;
            end
        end
    end

`ifdef TWOS_OVR_EN
    // Sticky overrun: set when a completed word had to be dropped.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            ovr <= 1'b0;
        end else if (done && out_valid && !out_ready) begin
            ovr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_twos_deserializer.sv
// Bench for twos_deserializer (WIDTH=8): directed serial words, a
// queue-based reference model compared every cycle, and literal checks.
module tb_twos_deserializer;

    localparam int W = 8;
`ifdef TWOS_OVR_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic         t_clk = 1'b0;
    logic         r_n = 1'b0;
    logic         i = 1'b0;
    logic         v = 1'b0;
    logic         sof = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] mag;
    logic         sign;
`ifdef TWOS_OVR_EN
    logic         ovr;
`endif

    twos_deserializer #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .i         (i),
        .v         (v),
        .sof       (sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag       (mag),
        .sign      (sign)
`ifdef TWOS_OVR_EN
        ,
        .ovr       (ovr)
`endif
    );

    always #5 t_clk = ~t_clk;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collect bits of a frame in a queue, then interpret
    // the whole word arithmetically as a signed value.
    bit    m_valid, m_sign, m_ovr, m_active;
    longint m_mag;
    bit    m_bits[$];

    always @(posedge t_clk or negedge r_n) begin : model
        bit     fin;
        longint word;
        if (!r_n) begin
            m_valid  = 0;
            m_sign   = 0;
            m_ovr    = 0;
            m_active = 0;
            m_mag    = 0;
            m_bits.delete();
        end else begin
            fin  = 0;
            word = 0;
            if (v) begin
                if (sof) begin
                    m_bits.delete();
                    m_bits.push_back(i);
                    m_active = 1;
                end else if (m_active) begin
                    m_bits.push_back(i);
                    if (m_bits.size() == W) begin
                        fin = 1;
                        m_active = 0;
                        foreach (m_bits[k]) word += longint'(m_bits[k]) << k;
                        m_bits.delete();
                    end
                end
            end
            if (fin) begin
                if (OVR && m_valid && !out_ready) begin
                    m_ovr = 1;
                end else begin
                    m_sign  = (word >= (longint'(1) << (W - 1)));
                    m_mag   = m_sign ? (longint'(1) << W) - word : word;
                    m_valid = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge t_clk) begin
        check("cmp_valid", out_valid, m_valid);
        check("cmp_mag", mag, m_mag);
        check("cmp_sign", sign, m_sign);
`ifdef TWOS_OVR_EN
        check("cmp_ovr", ovr, m_ovr);
`endif
        if (out_valid === 1'b1 && out_ready) n_xfer++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge t_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        v = 1'b1;
        i = b;
        sof = s;
        @(posedge t_clk);
        #1;
        v = 1'b0;
        sof = 1'b0;
        i = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) idle(gap);
            send_bit(w[k], k == 0);
        end
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int n0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_mag", mag, 0);
        check("rst_sign", sign, 0);
`ifdef TWOS_OVR_EN
        check("rst_ovr", ovr, 0);
`endif
        r_n = 1'b1;
        @(posedge t_clk);
        #1;

        // 0x05, no gaps
        send_word(8'h05, 0, 8);
        check("w05_valid", out_valid, 1);
        check("w05_mag", mag, 5);
        check("w05_sign", sign, 0);
        check("model_w05_mag", m_mag, 5);
        idle(2);
        check("w05_cleared", out_valid, 0);

        // -5 with 2-cycle gaps
        send_word(8'hFB, 2, 8);
        check("wfb_valid", out_valid, 1);
        check("wfb_mag", mag, 5);
        check("wfb_sign", sign, 1);
        check("model_wfb_sign", m_sign, 1);
        idle(2);

        // most negative
        send_word(8'h80, 0, 8);
        check("w80_mag", mag, 128);
        check("w80_sign", sign, 1);
        check("model_w80_mag", m_mag, 128);
        idle(2);

        // zero
        send_word(8'h00, 0, 8);
        check("w00_valid", out_valid, 1);
        check("w00_mag", mag, 0);
        check("w00_sign", sign, 0);
        idle(2);

        // abort after bit 4, then full 0xFF
        n0 = n_xfer;
        send_word(8'h03, 0, 5);
        send_word(8'hFF, 0, 8);
        check("abort_mag", mag, 1);
        check("abort_sign", sign, 1);
        idle(2);
        check("abort_count", n_xfer - n0, 1);

        // stalled consumer, two words
        out_ready = 1'b0;
        send_word(8'h05, 0, 8);
        idle(1);
        send_word(8'h07, 0, 8);
        idle(1);
        check("stall_valid", out_valid, 1);
        check("stall_mag", mag, OVR ? 5 : 7);
        check("stall_sign", sign, 0);
`ifdef TWOS_OVR_EN
        check("stall_ovr", ovr, 1);
`endif
        out_ready = 1'b1;
        @(posedge t_clk);
        #1;
        check("stall_release_valid", out_valid, 0);
        check("stall_release_mag", mag, OVR ? 5 : 7);

        // reset in the middle of 0x85
        send_word(8'h85, 0, 4);
        r_n = 1'b0;
        #2;
        check("midrst_valid", out_valid, 0);
        check("midrst_mag", mag, 0);
        check("midrst_sign", sign, 0);
`ifdef TWOS_OVR_EN
        check("midrst_ovr", ovr, 0);
`endif
        @(posedge t_clk);
        #1;
        r_n = 1'b1;
        for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0);
        idle(1);
        check("nosof_valid", out_valid, 0);
        send_word(8'h7F, 0, 8);
        check("w7f_valid", out_valid, 1);
        check("w7f_mag", mag, 127);
        check("w7f_sign", sign, 0);
        idle(2);

        // back-to-back words
        n0 = n_xfer;
        send_word(8'h01, 0, 8);
        check("b2b1_valid", out_valid, 1);
        check("b2b1_mag", mag, 1);
        check("b2b1_sign", sign, 0);
        send_word(8'hFF, 0, 8);
        check("b2b2_valid", out_valid, 1);
        check("b2b2_mag", mag, 1);
        check("b2b2_sign", sign, 1);
        idle(2);
        check("b2b_count", n_xfer - n0, 2);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twos_deserializer.md
TWOS_DESERIALIZER -- requirements
Module: twos_deserializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, serial word length in bits; legal range 2..32.
REQ-002 SHALL have port: t_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: r_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port: i  input  1  serial two's-complement data bit, LSB first.
REQ-005 SHALL have port: v  input  1  bit valid; i and sof are sampled only when v=1.
REQ-006 SHALL have port: sof  input  1  start of frame; qualifies the bit sampled with it as bit 0 of a new word.
REQ-007 SHALL have port: out_valid  output  1  mag/sign hold a completed word.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the word when out_valid=1.
REQ-009 SHALL have port: mag  output  WIDTH  magnitude of the received word.
REQ-010 SHALL have port: sign  output  1  1 = received word negative.
REQ-011 SHALL have port: ovr  output  1  sticky overrun flag; present only when TWOS_OVR_EN is defined.

Function
REQ-012 SHALL implement a receive FSM with states IDLE and RECV plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 IDLE: v=1 with sof=0 SHALL be ignored; v=1 with sof=1 SHALL capture bit 0, set counter to 1, and go to RECV.
REQ-014 RECV: each v=1 with sof=0 SHALL capture the next bit and increment the counter; v=0 cycles SHALL hold all state (gaps allowed).
REQ-015 RECV: v=1 with sof=1 SHALL abort the partial word without output and restart at bit 0 with the current bit.
REQ-016 Per captured bit, SHALL shift i into a raw register and, in parallel, shift neg_bit = seen_one ? ~i : i into a negated register, then set seen_one |= i; seen_one SHALL clear on every sof bit.
REQ-017 On capture of bit WIDTH-1 (MSB), SHALL return to IDLE and complete the word: sign = MSB; mag = sign ? negated word : raw word.
REQ-018 Most-negative input (MSB only set) SHALL produce mag = 2^(WIDTH-1), sign=1; zero SHALL produce mag=0, sign=0.
REQ-019 out_valid SHALL assert the cycle after the MSB is sampled (latency 1) and hold with mag/sign stable until out_valid & out_ready.
REQ-020 out_valid & out_ready with no completion that cycle SHALL clear out_valid next cycle.
REQ-021 Completion in the same cycle as out_valid & out_ready SHALL load the new word and keep out_valid=1; no overrun.
REQ-022 A sof bit in the cycle after MSB completion SHALL be accepted (back-to-back words, no dead cycle).
REQ-023 mag and sign SHALL change only on completion loads.

Reset
REQ-024 r_n=0 SHALL asynchronously force FSM=IDLE, counter=0, seen_one=0, raw/negated registers=0, out_valid=0, mag=0, sign=0, ovr=0.
REQ-025 Reset mid-word SHALL discard the partial word; first word after release needs a fresh sof.

Configuration
REQ-026 Macro TWOS_OVR_EN defined: completion while out_valid=1 and out_ready=0 SHALL drop the new word, keep the held word, and set ovr=1 until reset.
REQ-027 Macro TWOS_OVR_EN undefined: ovr port SHALL not exist; that completion SHALL overwrite mag/sign with the new word, out_valid staying 1.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-028 Bits 1,0,1,0,0,0,0,0 (0x05) with sof on first -> one cycle after MSB out_valid=1, mag=5, sign=0.
REQ-029 0xFB (-5) with v gaps of 2 cycles between bits -> mag=5, sign=1; 0x80 -> mag=128, sign=1; 0x00 -> mag=0, sign=0.
REQ-030 0x03 with new sof after bit 4, then full 0xFF -> only one output: mag=1, sign=1.
REQ-031 out_ready=0, words 0x05 then 0x07 -> with TWOS_OVR_EN: mag=5, ovr=1; without: mag=7; raising out_ready then clears out_valid next cycle.
REQ-032 r_n pulsed low after bit 3 of 0x85 -> all outputs 0 immediately; subsequent 0x7F with sof -> mag=127, sign=0.
REQ-033 Back-to-back 0x01 then 0xFF with sof in cycle after first MSB, out_ready=1 -> two out_valid words: mag=1/sign=0 then mag=1/sign=1.
